// File: rtl/round_sequencer.sv
// round_sequencer: iterative driver for an external combinational 32-bit keyed
// round function. One round per clock, round keys from an 8-bit Galois LFSR.
// Optional feature: define ROUND_SEQ_CHAIN_EN to XOR each new input word with
// the previously delivered output word (chain_reg).
module round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 8,
   parameter logic [7:0]  KEY_POLY   = 8'hB8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_DATA,
   input  logic [7:0]  KEY_SEED,
   output logic [31:0] R_D_IN,
   output logic [7:0]  R_K_IN,
   input  logic [31:0] R_D_OUT,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_DATA,
   output logic        BUSY
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [7:0] LastRound = 8'(NUM_ROUNDS - 1);

   state_e      fsm_q, fsm_d;
   logic [31:0] state_q, state_d;
   logic [7:0]  key_q, key_d;
   logic [7:0]  round_cnt_q, round_cnt_d;
   logic [31:0] out_data_q, out_data_d;
   logic [31:0] in_word;
   logic [7:0]  seed_fixed;
   logic [7:0]  key_next;

`ifdef ROUND_SEQ_CHAIN_EN
   logic [31:0] chain_q, chain_d;
   assign in_word = IN_DATA ^ chain_q;
`else
   assign in_word = IN_DATA;
`endif

   // An all-zero seed would lock the LFSR at zero, so substitute 8'h01.
   assign seed_fixed = (KEY_SEED == 8'h00) ? 8'h01 : KEY_SEED;
   assign key_next   = (key_q >> 1) ^ (key_q[0] ? KEY_POLY : 8'h00);

   assign R_D_IN    = state_q;
   assign R_K_IN    = key_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = (fsm_q == StDone);
   assign IN_READY  = (fsm_q == StIdle);
   assign BUSY      = (fsm_q != StIdle);

   // Next-state logic: accept in IDLE, iterate rounds in RUN, hold result in DONE.
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      key_d       = key_q;
      round_cnt_d = round_cnt_q;
      out_data_d  = out_data_q;
`ifdef ROUND_SEQ_CHAIN_EN
      chain_d     = chain_q;
`endif
      unique case (fsm_q)
         StIdle: begin
            if (IN_VALID) begin
               state_d     = in_word;
               key_d       = seed_fixed;
               round_cnt_d = 8'h00;
               fsm_d       = StRun;
            end
         end
         StRun: begin
            state_d     = R_D_OUT;
            key_d       = key_next;
            round_cnt_d = round_cnt_q + 8'h01;
            if (round_cnt_q == LastRound) begin
               out_data_d = R_D_OUT;
               fsm_d      = StDone;
            end
         end
         StDone: begin
            if (OUT_READY) begin
`ifdef ROUND_SEQ_CHAIN_EN
               chain_d = out_data_q;
`endif
               fsm_d   = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fsm_q       <= StIdle;
         state_q     <= 32'h0;
         key_q       <= 8'h01;
         round_cnt_q <= 8'h00;
         out_data_q  <= 32'h0;
`ifdef ROUND_SEQ_CHAIN_EN
         chain_q     <= 32'h0;
`endif
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         key_q       <= key_d;
         round_cnt_q <= round_cnt_d;
         out_data_q  <= out_data_d;
`ifdef ROUND_SEQ_CHAIN_EN
         chain_q     <= chain_d;
`endif
      end
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with an adder stub as round function.
// Two instances: NUM_ROUNDS=8 for the main sequence, NUM_ROUNDS=1 for the edge case.
module tb_round_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // NUM_ROUNDS = 8 instance
   logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] in_data, r_d_in, r_d_out, out_data;
   logic [7:0]  key_seed, r_k_in;

   // NUM_ROUNDS = 1 instance
   logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [31:0] in_data1, r_d_in1, r_d_out1, out_data1;
   logic [7:0]  key_seed1, r_k_in1;

   assign r_d_out  = r_d_in  + {24'h0, r_k_in};
   assign r_d_out1 = r_d_in1 + {24'h0, r_k_in1};

   round_sequencer #(.NUM_ROUNDS(8), .KEY_POLY(8'hB8)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DATA(in_data), .KEY_SEED(key_seed), .R_D_IN(r_d_in), .R_K_IN(r_k_in),
      .R_D_OUT(r_d_out), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_DATA(out_data), .BUSY(busy)
   );

   round_sequencer #(.NUM_ROUNDS(1), .KEY_POLY(8'hB8)) dut1 (
      .CLK(clk), .RST(rst1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
      .IN_DATA(in_data1), .KEY_SEED(key_seed1), .R_D_IN(r_d_in1), .R_K_IN(r_k_in1),
      .R_D_OUT(r_d_out1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
      .OUT_DATA(out_data1), .BUSY(busy1)
   );

   // Hand-computed LFSR sequence from seed 8'h01 with mask 8'hB8.
   logic [7:0] key_tab [8] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};

`ifdef ROUND_SEQ_CHAIN_EN
   localparam bit ChainEn = 1'b1;
`else
   localparam bit ChainEn = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one word on the 8-round instance and follow it to DONE.
   task automatic do_word(input logic [31:0] d, input logic [7:0] s, input logic [31:0] exp,
                          input string tag);
      in_valid = 1'b1;
      in_data  = d;
      key_seed = s;
      tick();
      in_valid = 1'b0;
      check({tag, " busy"}, {31'h0, busy}, 32'h1);
      check({tag, " in_ready"}, {31'h0, in_ready}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s key%0d", tag, i), {24'h0, r_k_in}, {24'h0, key_tab[i]});
         check($sformatf("%s early_valid%0d", tag, i), {31'h0, out_valid}, 32'h0);
         tick();
      end
      check({tag, " out_valid"}, {31'h0, out_valid}, 32'h1);
      check({tag, " out_data"}, out_data, exp);
   endtask

   task automatic out_handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " hs out_valid"}, {31'h0, out_valid}, 32'h0);
      check({tag, " hs in_ready"}, {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; key_seed = 8'h0; out_ready = 1'b0;
      rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = 32'h0; key_seed1 = 8'h0; out_ready1 = 1'b0;
      tick();
      tick();
      check("rst in_ready", {31'h0, in_ready}, 32'h1);
      check("rst out_valid", {31'h0, out_valid}, 32'h0);
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst out_data", out_data, 32'h0);
      check("rst r_d_in", r_d_in, 32'h0);
      check("rst r_k_in", {24'h0, r_k_in}, 32'h1);
      rst = 1'b0;
      rst1 = 1'b0;
      tick();

      // Basic word: seed 01, data 0.
      do_word(32'h0, 8'h01, 32'h0000_03B6, "w1");

      // Stall in DONE while IN_VALID toggles; nothing may change.
      in_data = 32'h0000_0055;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         tick();
         check($sformatf("hold valid%0d", i), {31'h0, out_valid}, 32'h1);
         check($sformatf("hold data%0d", i), out_data, 32'h0000_03B6);
         check($sformatf("hold in_ready%0d", i), {31'h0, in_ready}, 32'h0);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("after hs out_valid", {31'h0, out_valid}, 32'h0);
      check("after hs in_ready", {31'h0, in_ready}, 32'h1);
      check("after hs state kept", r_d_in, 32'h0000_03B6);
      tick();
      in_valid = 1'b0;
      check("idle accept busy", {31'h0, busy}, 32'h1);
      check("idle accept r_d_in", r_d_in, ChainEn ? 32'h0000_03E3 : 32'h0000_0055);

      // Reset at round 4 discards the in-flight word.
      tick(); tick(); tick(); tick();
      check("mid-run busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst in_ready", {31'h0, in_ready}, 32'h1);
      check("midrst out_valid", {31'h0, out_valid}, 32'h0);
      check("midrst busy", {31'h0, busy}, 32'h0);
      check("midrst r_k_in", {24'h0, r_k_in}, 32'h1);
      check("midrst r_d_in", r_d_in, 32'h0);

      // Zero seed behaves as seed 01; chain is cleared by the reset.
      do_word(32'h0, 8'h00, 32'h0000_03B6, "w_seed0");
      out_handshake("w_seed0");
      do_word(32'h0, 8'h01, ChainEn ? 32'h0000_076C : 32'h0000_03B6, "w_second");
      out_handshake("w_second");

      // Single-round instance.
      in_valid1 = 1'b1; in_data1 = 32'h0000_0010; key_seed1 = 8'h05;
      tick();
      in_valid1 = 1'b0;
      check("nr1 r_k_in", {24'h0, r_k_in1}, 32'h5);
      check("nr1 r_d_in", r_d_in1, 32'h0000_0010);
      check("nr1 early valid", {31'h0, out_valid1}, 32'h0);
      tick();
      check("nr1 out_valid", {31'h0, out_valid1}, 32'h1);
      check("nr1 out_data", out_data1, 32'h0000_0015);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("nr1 hs out_valid", {31'h0, out_valid1}, 32'h0);
      check("nr1 hs busy", {31'h0, busy1}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Iterative driver for the combinational 32-bit keyed round function in the TRNG post-processing chain. Accepts raw 32-bit TRNG words over a valid/ready handshake and presents state and an 8-bit round key to an external round-function instance, one round per clock. Captures the round-function output each cycle, generates round keys with an internal LFSR key schedule, and returns the final word over a second valid/ready handshake.

Parameters:
NUM_ROUNDS, 8, rounds per word; legal range 1..255.
KEY_POLY, 8'hB8, Galois LFSR feedback mask for the key schedule (8'hB8 gives period 255).

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
IN_VALID  input  1  IN_DATA/KEY_SEED valid
IN_READY  output  1  block can accept a word
IN_DATA  input  32  raw TRNG word
KEY_SEED  input  8  initial round key, sampled on input handshake
R_D_IN  output  32  state to round function
R_K_IN  output  8  round key to round function
R_D_OUT  input  32  round function result (combinational from R_D_IN/R_K_IN)
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  downstream accepts OUT_DATA
OUT_DATA  output  32  processed word
BUSY  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (CLK, RST).
- Reset: state IDLE, state_reg=0, key_reg=8'h01, round_cnt=0, OUT_DATA=0, OUT_VALID=0, IN_READY=1, BUSY=0.
- R_D_IN=state_reg, R_K_IN=key_reg continuously (combinational from registers).
- FSM states IDLE, RUN, DONE.
- IDLE: IN_READY=1. On IN_VALID: state_reg<=IN_DATA; key_reg<=KEY_SEED, or 8'h01 if KEY_SEED==0 (LFSR lock-up guard); round_cnt<=0; go RUN.
- RUN: IN_READY=0. Each cycle: state_reg<=R_D_OUT; key_reg<=(key_reg>>1) ^ (key_reg[0] ? KEY_POLY : 0); round_cnt<=round_cnt+1. When round_cnt==NUM_ROUNDS-1: OUT_DATA<=R_D_OUT, go DONE.
- DONE: OUT_VALID=1, OUT_DATA held stable, IN_READY=0. On OUT_READY: OUT_VALID<=0, go IDLE.
- Latency: OUT_VALID rises exactly NUM_ROUNDS+1 edges after the input handshake edge. Min throughput: one word per NUM_ROUNDS+2 cycles (IDLE bubble after output handshake is required).
- Round keys used: seed, L(seed), L^2(seed), ..., L^(NUM_ROUNDS-1)(seed).
- NUM_ROUNDS=1: RUN lasts one cycle, then DONE.
- IN_VALID in RUN/DONE: ignored, no state change. OUT_READY outside DONE: ignored.
- OUT_VALID, once high, stays high with constant OUT_DATA until OUT_READY.
- RST asserted in any state (including mid-RUN): in-flight word discarded, all registers return to reset values next edge.
- round_cnt is 8 bits; no wrap occurs within the legal NUM_ROUNDS range.

Optional Feature:
ROUND_SEQ_CHAIN_EN: when defined, adds 32-bit chain_reg (reset 0). On input handshake, state_reg<=IN_DATA ^ chain_reg; on output handshake, chain_reg<=OUT_DATA. Reset clears chain_reg. When undefined, no chain_reg exists and state_reg<=IN_DATA.

Test Plan:
- Bench stub round function R_D_OUT=R_D_IN+{24'h0,R_K_IN}, NUM_ROUNDS=8, KEY_SEED=8'h01, IN_DATA=0 -> R_K_IN sequence 01,B8,5C,2E,17,B3,E1,C8; OUT_DATA=32'h000003B6; OUT_VALID 9 edges after accept.
- KEY_SEED=8'h00, otherwise as above -> identical to seed 01 (OUT_DATA=32'h000003B6).
- OUT_READY held low 20 cycles in DONE, IN_VALID pulsed -> OUT_VALID/OUT_DATA stable, IN_READY=0, second word not accepted; accepted in the IDLE cycle after OUT_READY.
- NUM_ROUNDS=1, IN_DATA=32'h00000010, seed 8'h05 -> OUT_DATA=32'h00000015 two edges after accept.
- RST pulsed at round 4 -> next cycle IDLE, IN_READY=1, OUT_VALID=0; fresh word then gives the correct result.
- ROUND_SEQ_CHAIN_EN defined, two words IN_DATA=0, seed 01 -> outputs 32'h000003B6, then 32'h0000076C; after RST, first output is 32'h000003B6 again.
